// File: rtl/debug_dump_sequencer.sv
// Streams PC, register file and data memory out over a byte-wide UART handshake.
// Each word goes out MSB byte first; one dump is (1+NREGS+DM_WORDS) words.
module debug_dump_sequencer #(
  parameter int NBITS      = 32,
  parameter int NREGS      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DM_WORDS   = 16,
  parameter int DM_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NBITS-1:0]      pc_value,
  input  logic [NBITS-1:0]      reg_data,
  input  logic [NBITS-1:0]      dm_data,
  input  logic                  tx_done,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [DM_ADDR_W-1:0]  dm_addr,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int LAST_IDX = NREGS + DM_WORDS;
  localparam int IDX_W    = $clog2(LAST_IDX + 1);
  localparam int NBYTES   = NBITS / 8;
  localparam int BCNT_W   = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, WAIT, NEXT, FINISH} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_inc;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [BCNT_W-1:0]   byte_cnt_inc;
  logic [NBITS-1:0]    shift_reg;
  logic                is_last;

  assign idx_inc      = idx + IDX_W'(1);
  assign byte_cnt_inc = byte_cnt + BCNT_W'(1);
  assign is_last      = (idx == IDX_W'(LAST_IDX));
  assign tx_data      = shift_reg[NBITS-1 -: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   begin busy = 1'b1; state_nxt = CAPTURE; end
      CAPTURE: begin busy = 1'b1; state_nxt = SEND; end
      SEND:    begin busy = 1'b1; tx_start = 1'b1; state_nxt = WAIT; end
      WAIT: begin
        busy = 1'b1;
        if (tx_done) state_nxt = (byte_cnt_inc < BCNT_W'(NBYTES)) ? SEND : NEXT;
      end
      NEXT:    begin busy = 1'b1; state_nxt = is_last ? FINISH : FETCH; end
      FINISH:  begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses move on the NEXT->FETCH edge so read data is ready by the end of CAPTURE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
      reg_addr  <= '0;
      dm_addr   <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          byte_cnt <= '0;
          if (idx == '0)                   shift_reg <= pc_value;
          else if (int'(idx) <= NREGS)     shift_reg <= reg_data;
          else                             shift_reg <= dm_data;
        end
        WAIT: begin
          if (tx_done) begin
            shift_reg <= shift_reg << 8;
            byte_cnt  <= byte_cnt_inc;
          end
        end
        NEXT: begin
          if (!is_last) begin
            idx <= idx_inc;
            if (int'(idx_inc) <= NREGS) reg_addr <= REG_ADDR_W'(int'(idx_inc) - 1);
            else                        dm_addr  <= DM_ADDR_W'(int'(idx_inc) - NREGS - 1);
          end
        end
        FINISH:  idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: UART responder with random latency, memory models,
// and a word/byte reference stream built directly from the dump layout.
module tb_debug_dump_sequencer;

  localparam int NBITS    = 32;
  localparam int NREGS    = 32;
  localparam int DM_WORDS = 16;
  localparam int NTOT     = (1 + NREGS + DM_WORDS) * NBITS / 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        tx_done = 1'b0;
  logic [31:0] pc_value = '0;
  logic [31:0] reg_data, dm_data;
  logic [4:0]  reg_addr, dm_addr;
  logic        tx_start, busy, done;
  logic [7:0]  tx_data;

  int total = 0;
  int bad = 0;
  logic [7:0] got_q[$];
  int done_cnt;
  int first_ts_cyc;

  always #5 clk = ~clk;

  debug_dump_sequencer #(
    .NBITS(NBITS), .NREGS(NREGS), .REG_ADDR_W(5), .DM_WORDS(DM_WORDS), .DM_ADDR_W(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc_value(pc_value),
    .reg_data(reg_data), .dm_data(dm_data), .tx_done(tx_done),
    .reg_addr(reg_addr), .dm_addr(dm_addr), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .done(done)
  );

  // Synchronous-read memories: data follows the address one cycle later.
  always @(posedge clk) begin
    reg_data <= 32'(reg_addr) * 32'h01010101;
    dm_data  <= 32'hA0000000 + 32'(dm_addr);
  end

  function automatic logic [31:0] word_val(input int w, input logic [31:0] pc);
    if (w == 0)          return pc;
    else if (w <= NREGS) return 32'(w - 1) * 32'h01010101;
    else                 return 32'hA0000000 + 32'(w - NREGS - 1);
  endfunction

  function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pc);
    logic [31:0] v;
    v = word_val(k / 4, pc);
    return v[31 - 8 * (k % 4) -: 8];
  endfunction

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // UART responder: answers each tx_start after a delay, watching hold/extra-start/busy.
  task automatic serve(input int dly_lo, input int dly_hi, input int long_idx,
                       input int stop_after, input bit poke, input int budget);
    int cyc = 0;
    int cd = 0;
    int d;
    bit pend = 1'b0;
    bit fin = 1'b0;
    logic [7:0] held = '0;
    got_q.delete();
    done_cnt = 0;
    first_ts_cyc = -1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      start = 1'b0;
      if (pend) begin
        total++;
        if (tx_data !== held) begin
          bad++;
          $display("FAIL tx_data_hold byte %0d: got %h need %h", got_q.size() - 1, tx_data, held);
        end
        if (cd == 0) begin tx_done = 1'b1; pend = 1'b0; end
        else cd--;
        if (poke && got_q.size() == 5 && cd == 1) start = 1'b1;
      end
      if (tx_start) begin
        total++;
        if (pend) begin
          bad++;
          $display("FAIL extra_tx_start byte %0d: got tx_start=1 need 0", got_q.size());
        end
        got_q.push_back(tx_data);
        held = tx_data;
        pend = 1'b1;
        d = (got_q.size() - 1 == long_idx) ? 100 : int'($urandom_range(dly_hi, dly_lo));
        cd = d - 1;
        if (first_ts_cyc < 0) first_ts_cyc = cyc;
      end
      total++;
      if (done) begin
        done_cnt++;
        fin = 1'b1;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_done: got %b need 0", busy);
        end
      end else if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_during_dump cycle %0d: got %b need 1", cyc, busy);
      end
      if (stop_after > 0 && got_q.size() == stop_after && pend) fin = 1'b1;
    end
    tx_done = 1'b0;
    start = 1'b0;
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL serve_timeout: got %0d bytes in %0d cycles need completion", got_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b need 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h need 00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b need 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b need 0", done); end
    total++; if (reg_addr !== 5'd0) begin bad++; $display("FAIL reset_reg_addr: got %0d need 0", reg_addr); end
    total++; if (dm_addr !== 5'd0) begin bad++; $display("FAIL reset_dm_addr: got %0d need 0", dm_addr); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pc_latency();
    logic [7:0] exp4 [4];
    exp4 = '{8'h00, 8'h00, 8'h00, 8'h40};
    pc_value = 32'h00000040;
    start_pulse();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL latency_busy: got %b need 1", busy); end
    serve(4, 4, -1, 0, 1'b0, 4000);
    total++;
    if (first_ts_cyc != 2) begin bad++; $display("FAIL latency_tx_start: got cycle T+%0d need T+3", first_ts_cyc + 1); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got_q.size() <= k || got_q[k] !== exp4[k]) begin
        bad++; $display("FAIL pc_byte%0d: got %h need %h", k, (got_q.size() > k) ? got_q[k] : 8'hxx, exp4[k]);
      end
    end
    total++; if (got_q.size() != NTOT) begin bad++; $display("FAIL pc_dump_len: got %0d need %0d", got_q.size(), NTOT); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL pc_done_cnt: got %0d need 1", done_cnt); end
  endtask

  task automatic test_full_dump();
    logic [7:0] fixed_v [12];
    int         fixed_i [12];
    fixed_v = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h00, 8'h0F};
    fixed_i = '{4, 5, 6, 7, 132, 133, 134, 135, 192, 193, 194, 195};
    pc_value = $urandom;
    start_pulse();
    serve(1, 6, -1, 0, 1'b0, 4000);
    total++; if (got_q.size() != NTOT) begin bad++; $display("FAIL full_len: got %0d need %0d", got_q.size(), NTOT); end
    for (int k = 0; k < NTOT && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_byte(k, pc_value)) begin bad++; $display("FAIL full_byte%0d: got %h need %h", k, got_q[k], exp_byte(k, pc_value)); end
    end
    for (int j = 0; j < 12; j++) begin
      total++;
      if (got_q.size() <= fixed_i[j] || got_q[fixed_i[j]] !== fixed_v[j]) begin
        bad++; $display("FAIL full_fixed_byte%0d: need %h", fixed_i[j], fixed_v[j]);
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done_cnt: got %0d need 1", done_cnt); end
    repeat (5) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL full_after_done: got done=%b busy=%b need 0 0", done, busy); end
    end
  endtask

  task automatic test_ignored_inputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tx_done = c[0];
      total++;
      if (busy !== 1'b0 || tx_start !== 1'b0) begin bad++; $display("FAIL idle_tx_done: got busy=%b tx_start=%b need 0 0", busy, tx_start); end
    end
    @(negedge clk) tx_done = 1'b0;
    pc_value = $urandom;
    start_pulse();
    serve(2, 3, -1, 0, 1'b1, 4000);
    total++; if (got_q.size() != NTOT) begin bad++; $display("FAIL ignore_len: got %0d need %0d", got_q.size(), NTOT); end
    for (int k = 0; k < NTOT && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_byte(k, pc_value)) begin bad++; $display("FAIL ignore_byte%0d: got %h need %h", k, got_q[k], exp_byte(k, pc_value)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ignore_done_cnt: got %0d need 1", done_cnt); end
  endtask

  task automatic test_long_wait();
    pc_value = $urandom;
    start_pulse();
    serve(1, 2, 2, 0, 1'b0, 4000);
    total++; if (got_q.size() != NTOT) begin bad++; $display("FAIL long_len: got %0d need %0d", got_q.size(), NTOT); end
    for (int k = 0; k < NTOT && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_byte(k, pc_value)) begin bad++; $display("FAIL long_byte%0d: got %h need %h", k, got_q[k], exp_byte(k, pc_value)); end
    end
  endtask

  task automatic test_reset_mid();
    pc_value = $urandom;
    start_pulse();
    serve(1, 3, -1, 41, 1'b0, 4000);
    #2 reset = 1'b0;
    #1;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL abort_tx_start: got %b need 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL abort_tx_data: got %h need 00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b need 0", busy); end
    total++; if (reg_addr !== 5'd0 || dm_addr !== 5'd0) begin bad++; $display("FAIL abort_addr: got %0d/%0d need 0/0", reg_addr, dm_addr); end
    repeat (3) begin
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b need 0", done); end
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got done=%b busy=%b need 0 0", done, busy); end
    end
    pc_value = $urandom;
    start_pulse();
    serve(1, 4, -1, 0, 1'b0, 4000);
    total++;
    if (got_q.size() == 0 || got_q[0] !== pc_value[31:24]) begin
      bad++; $display("FAIL restart_first_byte: need %h", pc_value[31:24]);
    end
    for (int k = 0; k < NTOT && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_byte(k, pc_value)) begin bad++; $display("FAIL restart_byte%0d: got %h need %h", k, got_q[k], exp_byte(k, pc_value)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done_cnt: got %0d need 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] first_q[$];
    pc_value = $urandom;
    start_pulse();
    serve(1, 4, -1, 0, 1'b0, 4000);
    first_q = got_q;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b need 1", busy); end
    serve(1, 4, -1, 0, 1'b0, 4000);
    total++; if (got_q.size() != NTOT) begin bad++; $display("FAIL b2b_len: got %0d need %0d", got_q.size(), NTOT); end
    for (int k = 0; k < NTOT && k < got_q.size() && k < first_q.size(); k++) begin
      total++;
      if (got_q[k] !== first_q[k] || got_q[k] !== exp_byte(k, pc_value)) begin
        bad++; $display("FAIL b2b_byte%0d: got %h need %h", k, got_q[k], exp_byte(k, pc_value));
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_cnt: got %0d need 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_pc_latency();
    test_full_dump();
    test_ignored_inputs();
    test_long_wait();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_dump_sequencer.md
DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

Interface
REQ-001 Parameter NBITS, default 32, width of every dumped word.
REQ-002 Parameter NREGS, default 32, number of register-file words dumped.
REQ-003 Parameter REG_ADDR_W, default 5, register-file address width.
REQ-004 Parameter DM_WORDS, default 16, number of data-memory words dumped.
REQ-005 Parameter DM_ADDR_W, default 5, data-memory word-address width.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low; asserting it forces the reset state immediately, independent of clk.
REQ-008 start  in  1  one-cycle request to begin a dump; driven by the debug controller's send_flag.
REQ-009 pc_value  in  NBITS  current program counter.
REQ-010 reg_data  in  NBITS  register-file read data, valid one cycle after reg_addr changes.
REQ-011 dm_data  in  NBITS  data-memory read data, valid one cycle after dm_addr changes.
REQ-012 tx_done  in  1  UART transmitter finished the current byte (one-cycle pulse).
REQ-013 reg_addr  out  REG_ADDR_W  register-file read address.
REQ-014 dm_addr  out  DM_ADDR_W  data-memory read address.
REQ-015 tx_start  out  1  one-cycle pulse launching transmission of tx_data.
REQ-016 tx_data  out  8  byte to transmit, held stable from tx_start until the matching tx_done.
REQ-017 busy  out  1  high from the first cycle after an accepted start until done.
REQ-018 done  out  1  one-cycle pulse after the final byte's tx_done.

Function
REQ-019 Word index i runs 0..NREGS+DM_WORDS; word 0 = pc_value; words 1..NREGS = reg_data at reg_addr = i-1; remaining words = dm_data at dm_addr = i-NREGS-1.
REQ-020 FSM states: IDLE, FETCH, CAPTURE, SEND, WAIT, NEXT, FINISH.
REQ-021 IDLE -> FETCH when start=1; start in any other state is ignored.
REQ-022 FETCH: drive reg_addr/dm_addr for index i; one cycle; -> CAPTURE.
REQ-023 CAPTURE: latch the selected source into a NBITS shift register; byte counter = 0; -> SEND.
REQ-024 SEND: tx_start=1 for exactly one cycle, tx_data = shift register bits [NBITS-1:NBITS-8] (MSB byte first); -> WAIT.
REQ-025 WAIT: hold tx_data; on tx_done shift left by 8 and increment byte counter; -> SEND if byte counter < NBITS/8, else -> NEXT.
REQ-026 tx_done outside WAIT is ignored and changes no state.
REQ-027 NEXT: if i is the last index -> FINISH, else i <= i+1 and -> FETCH.
REQ-028 FINISH: done=1 for one cycle, busy=0 in that cycle, i <= 0; -> IDLE.
REQ-029 Latency: start sampled in cycle T gives busy=1 at T+1 and first tx_start at T+3.
REQ-030 reg_addr/dm_addr remain stable from FETCH through NEXT; they hold last value when not in use by the current word.
REQ-031 Total bytes per dump = (1+NREGS+DM_WORDS)*NBITS/8; with defaults 49 words, 196 bytes.
REQ-032 Index and byte counters never wrap; the last-index comparison ends the dump exactly once.

Reset
REQ-033 While reset=0: state IDLE, i=0, byte counter=0, shift register=0, reg_addr=0, dm_addr=0, tx_start=0, tx_data=0, busy=0, done=0.
REQ-034 Reset asserted mid-dump aborts immediately; no done pulse; a later start restarts at word 0.

Verification
REQ-035 pc_value=32'h00000040, start pulse, tx_done returned 4 cycles after each tx_start -> first four bytes 00,00,00,40; first tx_start 3 cycles after start.
REQ-036 Register model reg[k]=k*32'h01010101, DM model dm[k]=32'hA0000000+k -> bytes for word 1 = 00,00,00,00, word 33 = A0,00,00,00, last word = A0,00,00,0F; 196 tx_start pulses then exactly one done pulse.
REQ-037 start pulsed again during WAIT and tx_done pulsed during IDLE -> no effect on sequence, byte count or busy.
REQ-038 tx_done delayed 100 cycles -> tx_data stable and no extra tx_start throughout WAIT.
REQ-039 reset driven low between clock edges during word 10 -> all outputs zero immediately, no done; new start -> first byte again is the PC MSB.
REQ-040 Back-to-back: start asserted in the cycle after done -> second full 196-byte dump identical to the first.
